// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine.
// Holds the engine state encoding, the default word width, the edge-counter
// width and the values the configuration registers take on reset.
package spi_pkg;

  // Engine states: IDLE waits for strobes, SHIFT runs the SCK edges, and FIN
  // is the single DONE cycle. FIN also accepts a new START.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } spi_state_e;

  localparam int WIDTH_DEF = 8;

  // The edge counter must be able to hold 2*WIDTH.
  localparam int CNTW = $clog2(2 * WIDTH_DEF + 1);

  localparam logic        CPOL_RST = 1'b0;
  localparam logic        CPHA_RST = 1'b0;
  localparam int unsigned DIV_RST  = 0;

  // Returns the edge-counter width for a given word width.
  function automatic int spi_cntw(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// SCK half-period divider.
// When clr is high, the down-counter loads reload. After that, every enabled
// cycle that finds the counter at zero raises tick for one cycle and reloads
// the counter. So with enable held high, tick fires once every reload+1 cycles.
// Ports:
//   CLK, RST  clock and asynchronous active-high reset
//   clr       load the counter with reload (takes priority over en)
//   en        count enable
//   reload    half-period minus one
//   tick      combinational 1-cycle tick
module spi_clkdiv #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clr,
  input  logic            en,
  input  logic [DIVW-1:0] reload,
  output logic            tick
);

  logic [DIVW-1:0] cnt_r;

  // Down-counter: reload on clear or on expiry, otherwise decrement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {DIVW{1'b0}};
    end else if (clr) begin
      cnt_r <= reload;
    end else if (en) begin
      if (cnt_r == {DIVW{1'b0}}) begin
        cnt_r <= reload;
      end else begin
        cnt_r <= cnt_r - {{(DIVW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en & ~clr & (cnt_r == {DIVW{1'b0}});

endmodule

// File: rtl/spi_master_engine.sv
// Hardware SPI master for the extension CPLD.
// For each START it shifts one WIDTH-bit word, MSB first. The SCK divider,
// CPOL/CPHA mode and the slave selects are programmable. A legacy bit-bang
// path (BB_WR) can still drive SCK/MOSI directly while the engine is idle.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   CFG_WR + CFG_DIV/CPOL/CPHA/SS configuration strobe and fields
//   START + TXD                   begin a transfer of TXD
//   BB_WR + BB_SCK/BB_MOSI        legacy bit-bang pin write
//   MISO[NSS:0]                   per-slave MISO; MISO[NSS] is used when no slave is selected
//   SCK, MOSI, nSS                registered SPI pins
//   MISOX                         combinational MISO selected through nSS
//   RXD, DONE                     received word and its 1-cycle update pulse
//   BUSY                          transfer in progress
//   ERR                           sticky: a strobe arrived while busy
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int NSS   = 2,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIVW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WR,
  input  logic [DIVW-1:0]  CFG_DIV,
  input  logic             CFG_CPOL,
  input  logic             CFG_CPHA,
  input  logic [NSS-1:0]   CFG_SS,
  input  logic             START,
  input  logic [WIDTH-1:0] TXD,
  input  logic             BB_WR,
  input  logic             BB_SCK,
  input  logic             BB_MOSI,
  input  logic [NSS:0]     MISO,
  output logic             SCK,
  output logic             MOSI,
  output logic [NSS-1:0]   nSS,
  output logic             MISOX,
  output logic [WIDTH-1:0] RXD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int                CNTW_L    = spi_cntw(WIDTH);
  localparam logic [CNTW_L-1:0] LAST_EDGE = CNTW_L'(2 * WIDTH - 1);

  spi_state_e        state_r, state_nxt_s;
  logic [DIVW-1:0]   div_r;
  logic              cpol_r, cpha_r;
  logic [WIDTH-1:0]  tx_r, rx_r, rx_nxt_s;
  logic [CNTW_L-1:0] edge_r;
  logic              sck_r, mosi_r, busy_r, done_r, err_r;
  logic [NSS-1:0]    nss_r;
  logic [WIDTH-1:0]  rxd_r;

  logic              tick_s, idle_s, start_acc_s, cfg_acc_s, bb_acc_s, reject_s;
  logic              shift_tick_s, lead_s, last_s, finish_s, drive_s, sample_s;
  logic              cpol_eff_s, cpha_eff_s, misox_s;
  logic [DIVW-1:0]   reload_s;

  // Selected MISO: OR of the lines whose select is low. When no slave is selected, use the spare line.
  always_comb begin
    misox_s = 1'b0;
    if (&nss_r) begin
      misox_s = MISO[NSS];
    end else begin
      misox_s = |(MISO[NSS-1:0] & ~nss_r);
    end
  end

  // Strobe decode, edge classification and FSM next-state.
  always_comb begin
    state_nxt_s  = state_r;
    idle_s       = (state_r != SHIFT);
    start_acc_s  = idle_s & START;
    cfg_acc_s    = idle_s & CFG_WR;
    bb_acc_s     = idle_s & BB_WR;
    reject_s     = ~idle_s & (START | CFG_WR | BB_WR);
    shift_tick_s = (state_r == SHIFT) & tick_s;
    // edge_r counts edges already made, so the next edge is leading when edge_r is even
    lead_s       = ~edge_r[0];
    last_s       = (edge_r == LAST_EDGE);
    finish_s     = shift_tick_s & last_s;
    drive_s      = shift_tick_s & (cpha_r ? lead_s : (~lead_s & ~last_s));
    sample_s     = shift_tick_s & (cpha_r ? ~lead_s : lead_s);
    // A CFG_WR in the START cycle already applies to that transfer
    cpol_eff_s   = cfg_acc_s ? CFG_CPOL : cpol_r;
    cpha_eff_s   = cfg_acc_s ? CFG_CPHA : cpha_r;
    reload_s     = cfg_acc_s ? CFG_DIV : div_r;
    if (sample_s) begin
      rx_nxt_s = {rx_r[WIDTH-2:0], misox_s};
    end else begin
      rx_nxt_s = rx_r;
    end
    case (state_r)
      IDLE, FIN: begin
        if (START) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (finish_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Configuration, pins, shift registers and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_r  <= DIVW'(DIV_RST);
      cpol_r <= CPOL_RST;
      cpha_r <= CPHA_RST;
      nss_r  <= {NSS{1'b1}};
      sck_r  <= 1'b0;
      mosi_r <= 1'b0;
      tx_r   <= {WIDTH{1'b0}};
      rx_r   <= {WIDTH{1'b0}};
      rxd_r  <= {WIDTH{1'b0}};
      edge_r <= {CNTW_L{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= finish_s;

      if (cfg_acc_s) begin
        div_r  <= CFG_DIV;
        cpol_r <= CFG_CPOL;
        cpha_r <= CFG_CPHA;
        nss_r  <= CFG_SS;
      end

      if (reject_s) begin
        err_r <= 1'b1;
      end else if (cfg_acc_s) begin
        err_r <= 1'b0;
      end

      // A START overrides a bit-bang SCK. A bit-bang SCK overrides the CPOL idle level.
      if (start_acc_s) begin
        sck_r <= cpol_eff_s;
      end else if (bb_acc_s) begin
        sck_r <= BB_SCK;
      end else if (cfg_acc_s) begin
        sck_r <= CFG_CPOL;
      end else if (shift_tick_s) begin
        sck_r <= ~sck_r;
      end

      // For CPHA=0 the MSB is driven before the first edge, so the remaining bits are preloaded one position ahead.
      if (start_acc_s) begin
        if (!cpha_eff_s) begin
          mosi_r <= TXD[WIDTH-1];
          tx_r   <= {TXD[WIDTH-2:0], 1'b0};
        end else begin
          if (bb_acc_s) begin
            mosi_r <= BB_MOSI;
          end
          tx_r <= TXD;
        end
      end else if (bb_acc_s) begin
        mosi_r <= BB_MOSI;
      end else if (drive_s) begin
        mosi_r <= tx_r[WIDTH-1];
        tx_r   <= {tx_r[WIDTH-2:0], 1'b0};
      end

      if (start_acc_s) begin
        rx_r   <= {WIDTH{1'b0}};
        edge_r <= {CNTW_L{1'b0}};
        busy_r <= 1'b1;
      end else if (shift_tick_s) begin
        rx_r   <= rx_nxt_s;
        edge_r <= edge_r + CNTW_L'(1);
        if (finish_s) begin
          rxd_r  <= rx_nxt_s;
          busy_r <= 1'b0;
        end
      end
    end
  end

  spi_clkdiv #(.DIVW(DIVW)) u_clkdiv (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (start_acc_s),
    .en     (state_r == SHIFT),
    .reload (reload_s),
    .tick   (tick_s)
  );

  assign SCK   = sck_r;
  assign MOSI  = mosi_r;
  assign nSS   = nss_r;
  assign MISOX = misox_s;
  assign RXD   = rxd_r;
  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign ERR   = err_r;

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine (NSS=2, WIDTH=8, DIVW=4).
// A small behavioural SPI slave watches SCK edges. It shifts a reply word out
// on MISO and captures MOSI at its sample edges. The bench model tracks the
// config, ERR and the expected DONE latency 16*(DIV+1)+1.
module tb_spi_master_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CFG_WR, CFG_CPOL, CFG_CPHA, START, BB_WR, BB_SCK, BB_MOSI;
  logic [3:0] CFG_DIV;
  logic [1:0] CFG_SS;
  logic [7:0] TXD;
  logic [2:0] MISO;
  logic       SCK, MOSI, MISOX, BUSY, DONE, ERR;
  logic [1:0] nSS;
  logic [7:0] RXD;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_div;
  logic       m_cpol, m_cpha, m_err;
  logic [1:0] m_ss;

  spi_master_engine #(.NSS(2), .WIDTH(8), .DIVW(4)) dut (
    .CLK(CLK), .RST(RST), .CFG_WR(CFG_WR), .CFG_DIV(CFG_DIV), .CFG_CPOL(CFG_CPOL),
    .CFG_CPHA(CFG_CPHA), .CFG_SS(CFG_SS), .START(START), .TXD(TXD), .BB_WR(BB_WR),
    .BB_SCK(BB_SCK), .BB_MOSI(BB_MOSI), .MISO(MISO), .SCK(SCK), .MOSI(MOSI),
    .nSS(nSS), .MISOX(MISOX), .RXD(RXD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Selected lines carry the slave bit. Deselected lines carry noise that MISOX must ignore.
  task automatic drive_miso(input logic b);
    logic [2:0] v;
    v = 3'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (!m_ss[i]) v[i] = b;
    end
    if (&m_ss) v[2] = b;
    MISO = v;
  endtask

  task automatic do_cfg(input logic [3:0] div, input logic cpol, input logic cpha, input logic [1:0] ss);
    @(negedge CLK);
    CFG_DIV = div; CFG_CPOL = cpol; CFG_CPHA = cpha; CFG_SS = ss; CFG_WR = 1'b1;
    @(negedge CLK);
    CFG_WR = 1'b0;
    m_div = div; m_cpol = cpol; m_cpha = cpha; m_ss = ss; m_err = 1'b0;
    check("cfg_sck", 32'(SCK), 32'(cpol));
    check("cfg_nss", 32'(nSS), 32'(ss));
    check("cfg_err", 32'(ERR), 32'(1'b0));
  endtask

  // inj_kind: 0 none, 1 START, 2 CFG_WR, 3 BB_WR, asserted in cycle inj_cyc of the transfer
  task automatic run_xfer(input string tag, input logic [7:0] txd, input logic [7:0] slv,
                          input int inj_kind, input int inj_cyc, input bit b2b);
    int lat, done_cyc, edges, idx;
    logic prev, lead;
    logic [7:0] mosi_cap;
    lat = 16 * (int'(m_div) + 1) + 1;
    done_cyc = -1; edges = 0; mosi_cap = 8'h00;
    idx = m_cpha ? -1 : 0;
    @(negedge CLK);
    check({tag, "_idle_sck"}, 32'(SCK), 32'(m_cpol));
    prev = SCK;
    TXD = txd; START = 1'b1;
    drive_miso(m_cpha ? 1'b0 : slv[7]);
    for (int c = 1; c <= lat + 10; c++) begin
      @(posedge CLK); #1;
      START = 1'b0; CFG_WR = 1'b0; BB_WR = 1'b0;
      if (c == 1) begin
        check({tag, "_busy1"}, 32'(BUSY), 32'(1'b1));
        if (!m_cpha) check({tag, "_mosi1"}, 32'(MOSI), 32'(txd[7]));
      end
      if (SCK !== prev) begin
        edges++;
        lead = (edges % 2) == 1;
        if (lead != m_cpha) mosi_cap = {mosi_cap[6:0], MOSI};
        if (m_cpha ? lead : !lead) idx++;
        prev = SCK;
      end
      drive_miso((idx >= 0 && idx < 8) ? slv[7 - idx] : 1'b0);
      if (DONE === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (c == inj_cyc && inj_kind != 0) begin
        m_err = 1'b1;
        case (inj_kind)
          1: begin TXD = ~txd; START = 1'b1; end
          2: begin CFG_DIV = ~m_div; CFG_CPOL = ~m_cpol; CFG_CPHA = ~m_cpha; CFG_SS = ~m_ss; CFG_WR = 1'b1; end
          default: begin BB_SCK = ~SCK; BB_MOSI = ~MOSI; BB_WR = 1'b1; end
        endcase
      end
    end
    check({tag, "_latency"}, 32'(done_cyc), 32'(lat));
    check({tag, "_rxd"}, 32'(RXD), 32'(slv));
    check({tag, "_edges"}, 32'(edges), 32'd16);
    check({tag, "_mosi"}, 32'(mosi_cap), 32'(txd));
    check({tag, "_end_sck"}, 32'(SCK), 32'(m_cpol));
    check({tag, "_busy0"}, 32'(BUSY), 32'(1'b0));
    check({tag, "_err"}, 32'(ERR), 32'(m_err));
    check({tag, "_nss"}, 32'(nSS), 32'(m_ss));
    if (!b2b) begin
      @(posedge CLK); #1;
      check({tag, "_pulse"}, 32'(DONE), 32'(1'b0));
    end
  endtask

  initial begin
    int done_seen, l;
    logic [2:0] v;
    logic [1:0] ss_pat;
    RST = 1'b1; CFG_WR = 1'b0; CFG_DIV = 4'd0; CFG_CPOL = 1'b0; CFG_CPHA = 1'b0;
    CFG_SS = 2'b11; START = 1'b0; TXD = 8'h00; BB_WR = 1'b0; BB_SCK = 1'b0;
    BB_MOSI = 1'b0; MISO = 3'b000;
    m_div = 4'd0; m_cpol = 1'b0; m_cpha = 1'b0; m_ss = 2'b11; m_err = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_nss", 32'(nSS), 32'd3);
    check("rst_rxd", 32'(RXD), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;

    // Mode 0, fastest clock
    do_cfg(4'd0, 1'b0, 1'b0, 2'b10);
    run_xfer("t1", 8'hA5, 8'hA5, 0, 0, 1'b0);
    // Mode 3, DIV=3
    do_cfg(4'd3, 1'b1, 1'b1, 2'b01);
    run_xfer("t2", 8'h3C, 8'hC3, 0, 0, 1'b0);
    // START mid-transfer is rejected; CFG_WR in IDLE clears ERR
    do_cfg(4'd1, 1'b0, 1'b1, 2'b10);
    run_xfer("t3", 8'h5A, 8'h96, 1, 10, 1'b0);
    do_cfg(4'd1, 1'b0, 1'b1, 2'b10);
    // CFG_WR while busy leaves config and selects unchanged
    run_xfer("t3cfg", 8'h0F, 8'hF0, 2, 7, 1'b0);
    // Back-to-back: the second START lands in the DONE cycle
    do_cfg(4'd0, 1'b1, 1'b0, 2'b00);
    run_xfer("b2b_a", 8'h81, 8'h7E, 0, 0, 1'b1);
    run_xfer("b2b_b", 8'h24, 8'hDB, 0, 0, 1'b0);

    // MISOX select mux
    for (int p = 0; p < 3; p++) begin
      ss_pat = (p == 0) ? 2'b10 : ((p == 1) ? 2'b11 : 2'b00);
      do_cfg(4'd0, 1'b0, 1'b0, ss_pat);
      for (int k = 0; k < 8; k++) begin
        v = 3'(k);
        MISO = v;
        #1;
        check("misox", 32'(MISOX), 32'((p == 0) ? v[0] : ((p == 1) ? v[2] : (v[0] | v[1]))));
      end
    end

    // Bit-bang in IDLE, then bit-bang while busy
    @(negedge CLK);
    BB_SCK = 1'b1; BB_MOSI = 1'b1; BB_WR = 1'b1;
    @(negedge CLK);
    BB_WR = 1'b0;
    check("bb_sck", 32'(SCK), 32'd1);
    check("bb_mosi", 32'(MOSI), 32'd1);
    do_cfg(4'd2, 1'b0, 1'b0, 2'b01);
    run_xfer("bb_busy", 8'hC9, 8'h3A, 3, 20, 1'b0);

    // Async reset in cycle 7 aborts the transfer with no DONE
    do_cfg(4'd1, 1'b1, 1'b0, 2'b10);
    @(negedge CLK);
    TXD = 8'h77; START = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    check("pre_rst_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check("arst_sck", 32'(SCK), 32'd0);
    check("arst_mosi", 32'(MOSI), 32'd0);
    check("arst_nss", 32'(nSS), 32'd3);
    check("arst_rxd", 32'(RXD), 32'd0);
    check("arst_busy", 32'(BUSY), 32'd0);
    check("arst_err", 32'(ERR), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    m_div = 4'd0; m_cpol = 1'b0; m_cpha = 1'b0; m_ss = 2'b11; m_err = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    run_xfer("post_rst", 8'hE1, 8'h1E, 0, 0, 1'b0);

    // Randomized transfers
    for (int n = 0; n < 12; n++) begin
      do_cfg(4'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 2'($urandom));
      l = 16 * (int'(m_div) + 1) + 1;
      run_xfer("rnd", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(2, l - 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
